proj_frag_fetcher: RTL

Fragment-window responder for the extender datapath. It accepts a signed bit index requested by `proj_extender`, reads the reference-sequence memory word by word, and returns the `FRAG_LEN_BITS`-wide window starting at that index. Any bit that falls outside the reference is returned as zero. It sits between the extender's `out_index`/`in_fragment` pair and the on-chip reference memory, and replaces the combinational padding model with real memory accesses.

---
 rtl/proj_frag_fetcher.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/proj_frag_fetcher.sv
// proj_frag_fetcher: returns the FRAG_LEN_BITS-wide window of the on-chip
// reference that starts at a signed bit index. Bits outside the reference
// read as zero. Words are fetched one slot per cycle into an assembly
// buffer, which is then shifted by the intra-word offset into out_fragment.
// Optional feature macro: PROJ_FRAG_FETCH_PAD_FLAG_EN adds out_padded, set
// when any window bit fell outside the reference.
module proj_frag_fetcher #(
  parameter int FRAG_LEN_BITS     = 128,
  parameter int SIGNED_INDICE_LEN = 11,
  parameter int MEM_WORD_BITS     = 32,
  parameter int MEM_DEPTH         = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [SIGNED_INDICE_LEN-1:0]   req_index,
  output logic                           mem_rd_en,
  output logic [$clog2(MEM_DEPTH)-1:0]   mem_rd_addr,
  input  logic [MEM_WORD_BITS-1:0]       mem_rd_data,
  output logic                           frag_valid,
  input  logic                           frag_ready,
  output logic [FRAG_LEN_BITS-1:0]       out_fragment
`ifdef PROJ_FRAG_FETCH_PAD_FLAG_EN
  ,
  output logic                           out_padded
`endif
);

  localparam int NSLOT = FRAG_LEN_BITS / MEM_WORD_BITS + 1;
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int OW    = $clog2(MEM_WORD_BITS);
  localparam int SW    = $clog2(NSLOT);
  localparam int XW    = SIGNED_INDICE_LEN + 1;  // word-index arithmetic width
  localparam int BUF_W = NSLOT * MEM_WORD_BITS;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_ALIGN, S_HOLD} state_t;

  state_t                        state_reg, state_next;
  logic [SW-1:0]                 slot_reg, slot_next;
  logic [SIGNED_INDICE_LEN-1:0]  idx_reg;
  logic [BUF_W-1:0]              asm_buf_reg;
  logic                          cap_active_reg;
  logic                          cap_rd_reg;
  logic [SW-1:0]                 cap_slot_reg;
  logic [FRAG_LEN_BITS-1:0]      frag_reg;

  // Word index and bit offset of the latched request. The extra bit keeps
  // the extreme indices from wrapping when shifted.
  logic signed [XW-1:0] idx_ext;
  logic signed [XW-1:0] w0;
  logic [OW-1:0]        bit_off;

  assign idx_ext = {idx_reg[SIGNED_INDICE_LEN-1], idx_reg};
  assign w0      = idx_ext >>> OW;
  assign bit_off = idx_reg[OW-1:0];

  // Per-slot target word and whether it lies inside the reference.
  logic signed [XW-1:0] slot_word [NSLOT];
  logic [AW-1:0]        slot_addr [NSLOT];
  logic [NSLOT-1:0]     slot_hit;

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    assign slot_word[gi] = w0 + XW'(gi);
    assign slot_hit[gi]  = !slot_word[gi][XW-1] &&
                           (slot_word[gi] < $signed(XW'(MEM_DEPTH)));
    assign slot_addr[gi] = slot_word[gi][AW-1:0];
  end

  // State and slot counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      slot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
    end
  end

  // Next-state logic plus handshake and memory-strobe outputs.
  always_comb begin
    state_next  = state_reg;
    slot_next   = slot_reg;
    req_ready   = 1'b0;
    frag_valid  = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    case (state_reg)
      S_IDLE: begin
        req_ready = !rst;
        if (req_valid) begin
          state_next = S_FETCH;
          slot_next  = '0;
        end
      end
      S_FETCH: begin
        // Out-of-range slots simply skip the read; capture zeroes them.
        mem_rd_en = slot_hit[slot_reg];
        if (slot_hit[slot_reg]) mem_rd_addr = slot_addr[slot_reg];
        if (slot_reg == SW'(NSLOT - 1)) state_next = S_DRAIN;
        else                            slot_next  = slot_reg + 1'b1;
      end
      S_DRAIN: state_next = S_ALIGN;
      S_ALIGN: state_next = S_HOLD;
      S_HOLD: begin
        frag_valid = 1'b1;
        if (frag_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Latch the request, capture each slot one cycle after issue, then align.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg        <= '0;
      asm_buf_reg    <= '0;
      cap_active_reg <= 1'b0;
      cap_rd_reg     <= 1'b0;
      cap_slot_reg   <= '0;
      frag_reg       <= '0;
    end else begin
      if (state_reg == S_IDLE && req_valid) begin
        idx_reg     <= req_index;
        asm_buf_reg <= '0;
      end
      cap_active_reg <= (state_reg == S_FETCH);
      cap_rd_reg     <= mem_rd_en;
      cap_slot_reg   <= slot_reg;
      if (cap_active_reg)
        asm_buf_reg[cap_slot_reg*MEM_WORD_BITS +: MEM_WORD_BITS] <=
          cap_rd_reg ? mem_rd_data : '0;
      if (state_reg == S_ALIGN)
        frag_reg <= FRAG_LEN_BITS'(asm_buf_reg >> bit_off);
    end
  end

  assign out_fragment = frag_reg;

`ifdef PROJ_FRAG_FETCH_PAD_FLAG_EN
  localparam int PW = SIGNED_INDICE_LEN + 2;  // room for index + window length

  logic signed [PW-1:0] pad_start;
  logic signed [PW-1:0] pad_end;
  logic                 pad_reg;

  assign pad_start = {{2{idx_reg[SIGNED_INDICE_LEN-1]}}, idx_reg};
  assign pad_end   = pad_start + $signed(PW'(FRAG_LEN_BITS));

  // Window is padded if it starts before bit 0 or ends past the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_reg <= 1'b0;
    end else if (state_reg == S_ALIGN) begin
      pad_reg <= pad_start[PW-1] ||
                 (pad_end > $signed(PW'(MEM_DEPTH * MEM_WORD_BITS)));
    end
  end

  assign out_padded = pad_reg;
`endif

endmodule
